// File: rtl/pwm_trip_guard.sv
// Output protection stage for complementary PWM pairs: filtered fault and
// shoot-through detection force every pair to programmable safe levels until cleared.
module pwm_trip_guard #(
    parameter int unsigned PWM_WIDTH  = 8,
    parameter int unsigned FLT_WIDTH  = 4,
    parameter int unsigned FILT_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pwm_onoff,
    input  logic [PWM_WIDTH-1:0]  pwmin_A_x,
    input  logic [PWM_WIDTH-1:0]  pwmin_B_x,
    input  logic [FLT_WIDTH-1:0]  fault_in,
    input  logic [FLT_WIDTH-1:0]  fault_en,
    input  logic [FILT_WIDTH-1:0] fault_filt,
    input  logic                  st_en,
    input  logic [PWM_WIDTH-1:0]  safe_A_x,
    input  logic [PWM_WIDTH-1:0]  safe_B_x,
    input  logic                  trip_clear,
    output logic [PWM_WIDTH-1:0]  pwmout_A_x,
    output logic [PWM_WIDTH-1:0]  pwmout_B_x,
    output logic                  trip,
    output logic [FLT_WIDTH:0]    trip_cause,
    output logic                  fault_interrupt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        TRIPPED = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [FILT_WIDTH-1:0] cnt_q [FLT_WIDTH];
    logic [FILT_WIDTH-1:0] cnt_d [FLT_WIDTH];
    logic [PWM_WIDTH-1:0]  pwm_a_q, pwm_a_d;
    logic [PWM_WIDTH-1:0]  pwm_b_q, pwm_b_d;
    logic                  trip_q, trip_d;
    logic [FLT_WIDTH:0]    cause_q, cause_d;
    logic                  irq_q, irq_d;

    logic [FLT_WIDTH-1:0]  fault_act;
    logic [FLT_WIDTH-1:0]  qual;
    logic                  cnt_all_zero;
    logic                  st;
    logic                  trip_evt;

    // Per-line persistence filter: qualifies after fault_filt+1 consecutive high cycles.
    always_comb begin
        fault_act    = fault_in & fault_en;
        qual         = '0;
        cnt_all_zero = 1'b1;
        for (int j = 0; j < int'(FLT_WIDTH); j++) begin
            cnt_d[j] = '0;
            if (cnt_q[j] != '0) begin
                cnt_all_zero = 1'b0;
            end
            if (fault_act[j]) begin
                qual[j]  = (cnt_q[j] == fault_filt);
                cnt_d[j] = (cnt_q[j] < fault_filt) ? cnt_q[j] + FILT_WIDTH'(1) : fault_filt;
            end
        end
    end

    assign st       = st_en & (|(pwmin_A_x & pwmin_B_x));
    assign trip_evt = (|qual) | st;

    // Next state and registered outputs; safe levels are the default output.
    always_comb begin
        state_d = state_q;
        pwm_a_d = safe_A_x;
        pwm_b_d = safe_B_x;
        cause_d = cause_q;
        case (state_q)
            IDLE: begin
                if (trip_evt) begin
                    state_d = TRIPPED;
                end else if (pwm_onoff) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (trip_evt) begin
                    state_d = TRIPPED;
                end else if (!pwm_onoff) begin
                    state_d = IDLE;
                end else begin
                    pwm_a_d = pwmin_A_x;
                    pwm_b_d = pwmin_B_x;
                end
            end
            TRIPPED: begin
                if (trip_clear && !trip_evt && cnt_all_zero) begin
                    state_d = IDLE;
                    cause_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (trip_evt) begin
            cause_d = cause_q | {st, qual};
        end
        trip_d = (state_d == TRIPPED);
        irq_d  = (state_d == TRIPPED) && (state_q != TRIPPED);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pwm_a_q <= '0;
            pwm_b_q <= '0;
            trip_q  <= 1'b0;
            cause_q <= '0;
            irq_q   <= 1'b0;
            for (int j = 0; j < int'(FLT_WIDTH); j++) begin
                cnt_q[j] <= '0;
            end
        end else begin
            state_q <= state_d;
            pwm_a_q <= pwm_a_d;
            pwm_b_q <= pwm_b_d;
            trip_q  <= trip_d;
            cause_q <= cause_d;
            irq_q   <= irq_d;
            for (int j = 0; j < int'(FLT_WIDTH); j++) begin
                cnt_q[j] <= cnt_d[j];
            end
        end
    end

    assign pwmout_A_x      = pwm_a_q;
    assign pwmout_B_x      = pwm_b_q;
    assign trip            = trip_q;
    assign trip_cause      = cause_q;
    assign fault_interrupt = irq_q;

endmodule

// File: tb/tb_pwm_trip_guard.sv
// Scoreboard bench for pwm_trip_guard: a behavioural model predicts each cycle's
// outputs into a queue; an independent monitor pops and compares after every edge.
module tb_pwm_trip_guard;

    localparam int unsigned PW = 8;
    localparam int unsigned FW = 4;
    localparam int unsigned CW = 8;
    localparam int unsigned RW = 2 * PW + 1 + (FW + 1) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          pwm_onoff;
    logic [PW-1:0] pwmin_A_x, pwmin_B_x;
    logic [FW-1:0] fault_in, fault_en;
    logic [CW-1:0] fault_filt;
    logic          st_en;
    logic [PW-1:0] safe_A_x, safe_B_x;
    logic          trip_clear;
    logic [PW-1:0] pwmout_A_x, pwmout_B_x;
    logic          trip;
    logic [FW:0]   trip_cause;
    logic          fault_interrupt;

    int total = 0;
    int bad   = 0;

    logic [RW-1:0] exp_q[$];

    // Model state: consecutive-high run length per line, plus latched trip/run/cause.
    int            run_len [FW];
    bit            m_trip, m_run;
    logic [FW:0]   m_cause;

    always #5 clk = ~clk;

    pwm_trip_guard #(.PWM_WIDTH(PW), .FLT_WIDTH(FW), .FILT_WIDTH(CW)) dut (
        .clk             (clk),
        .reset           (reset),
        .pwm_onoff       (pwm_onoff),
        .pwmin_A_x       (pwmin_A_x),
        .pwmin_B_x       (pwmin_B_x),
        .fault_in        (fault_in),
        .fault_en        (fault_en),
        .fault_filt      (fault_filt),
        .st_en           (st_en),
        .safe_A_x        (safe_A_x),
        .safe_B_x        (safe_B_x),
        .trip_clear      (trip_clear),
        .pwmout_A_x      (pwmout_A_x),
        .pwmout_B_x      (pwmout_B_x),
        .trip            (trip),
        .trip_cause      (trip_cause),
        .fault_interrupt (fault_interrupt)
    );

    task automatic model_reset();
        m_trip  = 1'b0;
        m_run   = 1'b0;
        m_cause = '0;
        for (int j = 0; j < int'(FW); j++) run_len[j] = 0;
    endtask

    // Predict the outputs after the next edge from the inputs now applied, then clock.
    task automatic step();
        logic [FW-1:0] act, qual;
        logic          st, evt, all0, irq;
        logic [PW-1:0] oa, ob;
        act  = fault_in & fault_en;
        qual = '0;
        all0 = 1'b1;
        for (int j = 0; j < int'(FW); j++) begin
            // saturating counter value equals min(run length, filter length)
            if (run_len[j] != 0 && fault_filt != '0) all0 = 1'b0;
            if (act[j] && run_len[j] >= int'(fault_filt)) qual[j] = 1'b1;
        end
        st  = st_en && ((pwmin_A_x & pwmin_B_x) != '0);
        evt = st || (qual != '0);
        irq = 1'b0;
        oa  = safe_A_x;
        ob  = safe_B_x;
        if (evt) begin
            irq     = !m_trip;
            m_trip  = 1'b1;
            m_run   = 1'b0;
            m_cause = m_cause | {st, qual};
        end else if (m_trip) begin
            if (trip_clear && all0) begin
                m_trip  = 1'b0;
                m_cause = '0;
            end
        end else if (m_run) begin
            if (pwm_onoff) begin
                oa = pwmin_A_x;
                ob = pwmin_B_x;
            end else begin
                m_run = 1'b0;
            end
        end else begin
            m_run = pwm_onoff;
        end
        exp_q.push_back({oa, ob, m_trip, m_cause, irq});
        for (int j = 0; j < int'(FW); j++) begin
            if (act[j]) run_len[j] = (run_len[j] < 1000) ? run_len[j] + 1 : 1000;
            else        run_len[j] = 0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Monitor: reset values while reset is low, otherwise the scoreboard entry for this edge.
    initial begin
        logic [RW-1:0] act_v, exp_v;
        forever begin
            @(posedge clk or negedge reset);
            #1;
            act_v = {pwmout_A_x, pwmout_B_x, trip, trip_cause, fault_interrupt};
            if (!reset) begin
                total++;
                if (act_v !== '0) begin
                    bad++;
                    $display("FAIL reset_values t=%0t got A=%h B=%h trip=%b cause=%b irq=%b expected all zero",
                             $time, pwmout_A_x, pwmout_B_x, trip, trip_cause, fault_interrupt);
                end
            end else if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                total++;
                if (act_v !== exp_v) begin
                    bad++;
                    $display("FAIL cycle_outputs t=%0t got A=%h B=%h trip=%b cause=%b irq=%b expected A=%h B=%h trip=%b cause=%b irq=%b",
                             $time, pwmout_A_x, pwmout_B_x, trip, trip_cause, fault_interrupt,
                             exp_v[RW-1 -: PW], exp_v[RW-1-PW -: PW], exp_v[FW+2],
                             exp_v[FW+1:1], exp_v[0]);
                end
            end
        end
    end

    initial begin
        int wait_cyc;
        reset      = 1'b1;
        pwm_onoff  = 1'b0;
        pwmin_A_x  = '0;
        pwmin_B_x  = '0;
        fault_in   = '0;
        fault_en   = 4'b0001;
        fault_filt = 8'd3;
        st_en      = 1'b1;
        safe_A_x   = 8'h00;
        safe_B_x   = 8'hFF;
        trip_clear = 1'b0;
        #1 reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_reset();

        // Pass-through
        pwm_onoff = 1'b1;
        pwmin_A_x = 8'hA5;
        pwmin_B_x = 8'h5A;
        steps(4);

        // Filter: 3 high cycles is not enough, 4 trips
        fault_in = 4'b0001; steps(3);
        fault_in = 4'b0000; steps(1);
        fault_in = 4'b0001; steps(6);

        // Clear while fault still high is ignored; clear colliding with qualified fault
        trip_clear = 1'b1; steps(2);
        trip_clear = 1'b0;

        // Second line during trip: cause bit set, no new interrupt
        fault_en = 4'b0011;
        fault_in = 4'b0011; steps(5);

        // Release, then clear, then resume
        fault_in = 4'b0000; steps(2);
        trip_clear = 1'b1; steps(1);
        trip_clear = 1'b0; steps(4);

        // Shoot-through enabled trips immediately
        pwmin_A_x = 8'h04; pwmin_B_x = 8'h04; steps(1);
        pwmin_A_x = 8'hA5; pwmin_B_x = 8'h5A; steps(2);
        trip_clear = 1'b1; steps(1);
        trip_clear = 1'b0; steps(3);

        // Shoot-through disabled is ignored
        st_en = 1'b0;
        pwmin_A_x = 8'h04; pwmin_B_x = 8'h04; steps(2);
        pwmin_A_x = 8'hA5; pwmin_B_x = 8'h5A; steps(1);

        // Async reset mid-trip, then IDLE -> RUN
        st_en = 1'b1;
        pwmin_A_x = 8'h10; pwmin_B_x = 8'h10; steps(1);
        pwmin_A_x = 8'h3C; pwmin_B_x = 8'hC3; steps(2);
        #2 reset = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        steps(4);

        // Randomised segments, filter length changed only while all lines are low
        for (int seg = 0; seg < 6; seg++) begin
            fault_in   = '0;
            trip_clear = 1'b0;
            fault_filt = CW'($urandom_range(0, 4));
            fault_en   = FW'($urandom);
            steps(1);
            for (int i = 0; i < 500; i++) begin
                logic [FW-1:0] flip;
                flip = '0;
                for (int j = 0; j < int'(FW); j++) flip[j] = ($urandom_range(0, 5) == 0);
                fault_in   = fault_in ^ flip;
                pwm_onoff  = ($urandom_range(0, 9) != 0);
                pwmin_A_x  = PW'($urandom);
                pwmin_B_x  = ($urandom_range(0, 19) == 0) ? PW'($urandom) : ~pwmin_A_x;
                st_en      = ($urandom_range(0, 3) != 0);
                trip_clear = ($urandom_range(0, 5) == 0);
                if ($urandom_range(0, 49) == 0) begin
                    safe_A_x = PW'($urandom);
                    safe_B_x = PW'($urandom);
                end
                step();
            end
        end

        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 10) begin
            @(negedge clk);
            wait_cyc++;
        end
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain got %0d pending entries expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pwm_trip_guard.md
Name: pwm_trip_guard

Overview:
- Output protection stage directly downstream of cpwm_16bits_8carr.
- Consumes the 8 complementary PWM pairs (pwmout_A_x/pwmout_B_x) and passes them to the pads. Pass-through latency is one clock.
- Forces every pair to programmable safe levels on either of two conditions:
  - a filtered external fault, or
  - a shoot-through condition (A and B high together).
- A trip latches until software clears it; cause reporting and a trip interrupt are provided.

Parameters:
- PWM_WIDTH, 8, number of PWM pairs.
- FLT_WIDTH, 4, number of external fault inputs.
- FILT_WIDTH, 8, width of each fault filter counter.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- pwm_onoff  input  1  global enable; 1 = run.
- pwmin_A_x  input  PWM_WIDTH  A outputs from the PWM core.
- pwmin_B_x  input  PWM_WIDTH  B outputs from the PWM core.
- fault_in  input  FLT_WIDTH  external fault lines, active-high, already synchronised.
- fault_en  input  FLT_WIDTH  per-line fault enable.
- fault_filt  input  FILT_WIDTH  filter length, shared by all lines.
- st_en  input  1  shoot-through detection enable.
- safe_A_x  input  PWM_WIDTH  safe level for each A output.
- safe_B_x  input  PWM_WIDTH  safe level for each B output.
- trip_clear  input  1  single-cycle clear request.
- pwmout_A_x  output  PWM_WIDTH  guarded A outputs, registered.
- pwmout_B_x  output  PWM_WIDTH  guarded B outputs, registered.
- trip  output  1  high while in TRIPPED.
- trip_cause  output  FLT_WIDTH+1  sticky causes; bit FLT_WIDTH = shoot-through.
- fault_interrupt  output  1  one-cycle pulse on entry to TRIPPED.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; all filter counters=0; pwmout_A_x=0, pwmout_B_x=0, trip=0, trip_cause=0, fault_interrupt=0.
- Fault filter, per line j:
  - cnt[j] increments each cycle while fault_in[j]&fault_en[j]=1; it saturates at fault_filt.
  - cnt[j] returns to 0 on any cycle where fault_in[j]&fault_en[j]=0.
  - qual[j] = (fault_in[j]&fault_en[j]) & (cnt[j]==fault_filt). The line must be high for fault_filt+1 consecutive cycles; fault_filt=0 qualifies on the first high cycle.
- Shoot-through: st = st_en & |(pwmin_A_x & pwmin_B_x). It is not filtered.
- trip_evt = |qual | st.
- States:
  - IDLE: outputs load safe_A_x/safe_B_x each edge. trip_evt -> TRIPPED. Else pwm_onoff=1 -> RUN.
  - RUN: outputs load pwmin_A_x/pwmin_B_x each edge (1-cycle latency).
    - trip_evt -> TRIPPED; on the same edge the outputs load the safe levels, so the offending sample never reaches the pins.
    - Else pwm_onoff=0 -> IDLE, with safe levels loaded on that edge.
  - TRIPPED: outputs load safe levels; trip=1; pwm_onoff is ignored.
    - trip_clear=1 with trip_evt=0 and all cnt==0 -> IDLE; trip_cause is cleared on that edge.
    - trip_clear under any other condition is ignored.
- trip_cause:
  - On every edge where trip_evt=1 (in any state), ORs in {st, qual}.
  - Holds otherwise; cleared only by an accepted clear or by reset.
- fault_interrupt = 1 for exactly the one cycle following the edge that enters TRIPPED. There is no re-pulse while already in TRIPPED.
- Simultaneous events:
  - trip_evt with trip_clear: trip_evt wins, state stays TRIPPED.
  - trip_evt with pwm_onoff falling: goes to TRIPPED.
  - trip_evt in IDLE: goes to TRIPPED.
- Restart after clear:
  - After an accepted clear the block spends at least one cycle in IDLE (safe levels).
  - It reaches RUN on the next edge if pwm_onoff=1.
- Changing fault_filt while a line is counting: the comparison uses the current value; counters above the new value saturate at it.
- Reset asserted mid-trip: immediately returns to the reset values; the trip is not retained.

Test Plan:
- Pass-through: reset release, pwm_onoff=1, no faults, pwmin_A_x=8'hA5, pwmin_B_x=8'h5A -> pwmout_A_x/pwmout_B_x equal the inputs one clk later; trip=0.
- Filter: fault_filt=3, fault_en=4'b0001, fault_in[0] high for 3 cycles then low -> no trip. Held 4 cycles -> trip=1 after the 4th edge, pwmout = safe_A_x=8'h00/safe_B_x=8'hFF, trip_cause=5'b00001, fault_interrupt pulses once.
- Shoot-through: st_en=1, pwmin_A_x[2]=pwmin_B_x[2]=1 for one cycle -> TRIPPED on that edge, trip_cause=5'b10000. Repeat with st_en=0 -> no trip.
- Clear rules:
  - trip_clear while fault_in[0] still high -> ignored.
  - Release the fault, then trip_clear -> trip=0, trip_cause=0, safe levels for 1 cycle, then pass-through resumes with pwm_onoff=1.
- Collisions: qualified fault and trip_clear on the same cycle -> stays TRIPPED. Second fault line during TRIPPED -> its trip_cause bit also set, no second interrupt.
- Async reset: assert reset mid-TRIPPED between clock edges -> outputs, trip and trip_cause go to 0 immediately. After release, IDLE drives safe levels, then RUN.
